// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Also used by the optional HAZARD_PERF_EN counter build.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        BR_FLUSH   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam int unsigned REG_ZERO = 32'd0;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// EX-stage forwarding select for one ALU operand; the MEM producer wins over WB,
// and x0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rd_mem_i,
    input  logic             regwrite_mem_i,
    input  logic [REG_W-1:0] rd_wb_i,
    input  logic             regwrite_wb_i,
    output fwd_sel_t         sel_o
);

    // Priority select: MEM result, then WB write data, then register file
    always_comb begin
        sel_o = FWD_REG;
        if (regwrite_mem_i && (rd_mem_i != REG_W'(REG_ZERO)) && (rd_mem_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (regwrite_wb_i && (rd_wb_i != REG_W'(REG_ZERO)) && (rd_wb_i == rs_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, taken-branch flush and forwarding control for the 5-stage core.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic [REG_W-1:0] rs1_EX,
    input  logic [REG_W-1:0] rs2_EX,
    input  logic [REG_W-1:0] rd_EX,
    input  logic [REG_W-1:0] rd_MEM,
    input  logic [REG_W-1:0] rd_WB,
    input  logic             MemRead_EX,
    input  logic             RegWrite_MEM,
    input  logic             RegWrite_WB,
    input  logic             PCSrc,
    output logic             PCWrite,
    output logic             ifid_ena,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`ifdef HAZARD_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    state_t   state_q;
    state_t   state_d;
    logic     load_use_s;
    logic     lu_mask_s;
    logic     lu_eff_s;
    fwd_sel_t fwd_a_s;
    fwd_sel_t fwd_b_s;

    assign load_use_s = MemRead_EX && (rd_EX != REG_W'(REG_ZERO)) &&
                        ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

    // After a flush ID/EX holds a bubble, so a stale load match is ignored
    always_comb begin
        lu_mask_s = 1'b0;
        case (state_q)
            RUN:        lu_mask_s = 1'b0;
            LOAD_STALL: lu_mask_s = 1'b0;
            BR_FLUSH:   lu_mask_s = 1'b1;
            default:    lu_mask_s = 1'b0;
        endcase
    end

    assign lu_eff_s = load_use_s && !lu_mask_s;

    // Stall/flush outputs and next state; the branch flush outranks a load-use stall
    always_comb begin
        PCWrite     = 1'b1;
        ifid_ena    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = RUN;
        if (RESET) begin
            PCWrite     = 1'b0;
            ifid_ena    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
        end else if (PCSrc) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = BR_FLUSH;
        end else if (lu_eff_s) begin
            PCWrite     = 1'b0;
            ifid_ena    = 1'b0;
            idex_flush  = 1'b1;
            state_d     = LOAD_STALL;
        end else begin
            state_d     = RUN;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .rs_i           (rs1_EX),
        .rd_mem_i       (rd_MEM),
        .regwrite_mem_i (RegWrite_MEM),
        .rd_wb_i        (rd_WB),
        .regwrite_wb_i  (RegWrite_WB),
        .sel_o          (fwd_a_s)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .rs_i           (rs2_EX),
        .rd_mem_i       (rd_MEM),
        .regwrite_mem_i (RegWrite_MEM),
        .rd_wb_i        (rd_WB),
        .regwrite_wb_i  (RegWrite_WB),
        .sel_o          (fwd_b_s)
    );

    // Forwarding selects fall back to the register file while in reset
    always_comb begin
        if (RESET) begin
            fwd_a = FWD_REG;
            fwd_b = FWD_REG;
        end else begin
            fwd_a = fwd_a_s;
            fwd_b = fwd_b_s;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             stall_ev_s;
    logic             flush_ev_s;

    assign stall_ev_s = !RESET && !PCSrc && lu_eff_s;
    assign flush_ev_s = !RESET && PCSrc;

    // Saturating event counters; perf_clr beats a same-cycle increment
    always_ff @(posedge CLK) begin
        if (RESET || perf_clr) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (stall_ev_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_ev_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt = RESET ? {CNT_W{1'b0}} : stall_cnt_q;
    assign flush_cnt = RESET ? {CNT_W{1'b0}} : flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected control vectors and counter values
// are queued as stimulus is applied and checked mid-cycle.
module tb_hazard_unit;

    localparam int SAT = 15;
    localparam logic [8:0] V_RST   = 9'b001110000;
    localparam logic [8:0] V_RUN   = 9'b110000000;
    localparam logic [8:0] V_STALL = 9'b000100000;
    localparam logic [8:0] V_FLUSH = 9'b111110000;

    logic       CLK, RESET;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
    logic       MemRead_EX, RegWrite_MEM, RegWrite_WB, PCSrc, perf_clr;
    logic       PCWrite, ifid_ena, ifid_flush, idex_flush, exmem_flush;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    typedef struct {
        string      name;
        logic [8:0] vec;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_stall  = 0;
    int   m_flush  = 0;
    wire [8:0] obs = {PCWrite, ifid_ena, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b};

    hazard_unit #(
        .REG_W(5)
`ifdef HAZARD_PERF_EN
        , .CNT_W(4)
`endif
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
        .MemRead_EX(MemRead_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .PCSrc(PCSrc), .PCWrite(PCWrite), .ifid_ena(ifid_ena),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_EN
        , .perf_clr(perf_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic clear_in();
        rs1_ID = 5'd1; rs2_ID = 5'd2; rs1_EX = 5'd3; rs2_EX = 5'd4;
        rd_EX = 5'd10; rd_MEM = 5'd11; rd_WB = 5'd12;
        MemRead_EX = 1'b0; RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
        PCSrc = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_lu(input bit use_rs2);
        MemRead_EX = 1'b1;
        rd_EX      = 5'd5;
        if (use_rs2) rs2_ID = 5'd5;
        else         rs1_ID = 5'd5;
    endtask

    // Queue this cycle's expectation; counters show events up to the previous edge
    task automatic push_exp(input string name, input logic [8:0] vec);
        exp_t x;
        x.name = name;
        x.vec  = vec;
        x.sc   = RESET ? 0 : m_stall;
        x.fc   = RESET ? 0 : m_flush;
        sb.push_back(x);
        if (RESET || perf_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!vec[8] && m_stall < SAT) m_stall++;
            if (PCSrc && m_flush < SAT) m_flush++;
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            clear_in();
            RESET = 1'b1;
            set_lu(1'b0);
            PCSrc = 1'b1;
            RegWrite_MEM = 1'b1; rd_MEM = 5'd3;
            RegWrite_WB  = 1'b1; rd_WB  = 5'd4;
            push_exp($sformatf("reset%0d", i), V_RST);
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
`ifdef HAZARD_PERF_EN
            n_checks += 2;
            if (stall_cnt !== e.sc[3:0]) begin n_fail++; $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc); end
            if (flush_cnt !== e.fc[3:0]) begin n_fail++; $display("FAIL %s flush_cnt got=%0d want=%0d", e.name, flush_cnt, e.fc); end
`endif
            next_cycle();
        end
        RESET = 1'b0;
    endtask

    task automatic test_load_use();
        logic [8:0] v[5] = '{V_STALL, V_RUN, V_STALL, V_RUN, V_RUN};
        for (int i = 0; i < 5; i++) begin
            clear_in();
            if (i == 0) set_lu(1'b0);
            if (i == 2) set_lu(1'b1);
            if (i == 4) begin rd_EX = 5'd5; rs1_ID = 5'd5; end
            push_exp($sformatf("load_use%0d", i), v[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
`ifdef HAZARD_PERF_EN
            n_checks += 2;
            if (stall_cnt !== e.sc[3:0]) begin n_fail++; $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc); end
            if (flush_cnt !== e.fc[3:0]) begin n_fail++; $display("FAIL %s flush_cnt got=%0d want=%0d", e.name, flush_cnt, e.fc); end
`endif
            next_cycle();
        end
    endtask

    // Flush beats stall; the cycle after a flush ignores a load match
    task automatic test_branch();
        bit         pc[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit         lu[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0] v[7]  = '{V_FLUSH, V_RUN, V_STALL, V_FLUSH, V_FLUSH, V_RUN, V_RUN};
        for (int i = 0; i < 7; i++) begin
            clear_in();
            if (lu[i]) set_lu(i == 5);
            PCSrc = pc[i];
            push_exp($sformatf("branch%0d", i), v[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
`ifdef HAZARD_PERF_EN
            n_checks += 2;
            if (stall_cnt !== e.sc[3:0]) begin n_fail++; $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc); end
            if (flush_cnt !== e.fc[3:0]) begin n_fail++; $display("FAIL %s flush_cnt got=%0d want=%0d", e.name, flush_cnt, e.fc); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_forward();
        bit         wm[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] rm[5]  = '{5'd7, 5'd7, 5'd3, 5'd3, 5'd3};
        bit         ww[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0] rw[5]  = '{5'd7, 5'd7, 5'd4, 5'd4, 5'd3};
        logic [4:0] ra[5]  = '{5'd7, 5'd7, 5'd3, 5'd3, 5'd9};
        logic [4:0] rb[5]  = '{5'd7, 5'd7, 5'd4, 5'd4, 5'd3};
        logic [3:0] ab[5]  = '{4'b1010, 4'b0101, 4'b1001, 4'b1000, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            clear_in();
            RegWrite_MEM = wm[i]; rd_MEM = rm[i];
            RegWrite_WB  = ww[i]; rd_WB  = rw[i];
            rs1_EX = ra[i]; rs2_EX = rb[i];
            push_exp($sformatf("fwd%0d", i), V_RUN | {5'b00000, ab[i]});
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
`ifdef HAZARD_PERF_EN
            n_checks += 2;
            if (stall_cnt !== e.sc[3:0]) begin n_fail++; $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc); end
            if (flush_cnt !== e.fc[3:0]) begin n_fail++; $display("FAIL %s flush_cnt got=%0d want=%0d", e.name, flush_cnt, e.fc); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_x0();
        for (int i = 0; i < 2; i++) begin
            clear_in();
            MemRead_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd0;
            rs1_EX = 5'd0; rs2_EX = 5'd0;
            if (i == 0) begin RegWrite_MEM = 1'b1; rd_MEM = 5'd0; end
            else        begin RegWrite_WB  = 1'b1; rd_WB  = 5'd0; end
            push_exp($sformatf("x0_%0d", i), V_RUN);
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
`ifdef HAZARD_PERF_EN
            n_checks += 2;
            if (stall_cnt !== e.sc[3:0]) begin n_fail++; $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc); end
            if (flush_cnt !== e.fc[3:0]) begin n_fail++; $display("FAIL %s flush_cnt got=%0d want=%0d", e.name, flush_cnt, e.fc); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_stall();
        bit         rs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit         lu[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [8:0] v[4]  = '{V_STALL, V_RST, V_RUN, V_STALL};
        for (int i = 0; i < 4; i++) begin
            clear_in();
            RESET = rs[i];
            if (lu[i]) set_lu(1'b0);
            push_exp($sformatf("rst_stall%0d", i), v[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
`ifdef HAZARD_PERF_EN
            n_checks += 2;
            if (stall_cnt !== e.sc[3:0]) begin n_fail++; $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc); end
            if (flush_cnt !== e.fc[3:0]) begin n_fail++; $display("FAIL %s flush_cnt got=%0d want=%0d", e.name, flush_cnt, e.fc); end
`endif
            next_cycle();
        end
        RESET = 1'b0;
        // A final reset cycle clears the counters before the saturation run
        clear_in();
        RESET = 1'b1;
        push_exp("rst_clear", V_RST);
        @(negedge CLK);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
        next_cycle();
        RESET = 1'b0;
    endtask

    task automatic test_back_to_back_stall();
        for (int i = 0; i < 20; i++) begin
            clear_in();
            if (i != 18) set_lu(1'b0);
            perf_clr = (i == 17);
            push_exp($sformatf("sat%0d", i), (i == 18) ? V_RUN : V_STALL);
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s ctrl got=%b want=%b", e.name, obs, e.vec); end
`ifdef HAZARD_PERF_EN
            n_checks += 2;
            if (stall_cnt !== e.sc[3:0]) begin n_fail++; $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc); end
            if (flush_cnt !== e.fc[3:0]) begin n_fail++; $display("FAIL %s flush_cnt got=%0d want=%0d", e.name, flush_cnt, e.fc); end
`endif
            next_cycle();
        end
    endtask

    initial begin
        clear_in();
        RESET = 1'b1;
        next_cycle();
        test_reset();
        test_load_use();
        test_branch();
        test_forward();
        test_x0();
        test_reset_mid_stall();
        test_back_to_back_stall();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
